// File: rtl/run_ctrl_watchdog_pkg.sv
// Shared types and helpers for the run controller: FSM state encoding and counter sizing.
package run_ctrl_watchdog_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  // Bits needed to hold 0..max_val; never narrower than one bit so a disabled counter still elaborates.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/run_ctrl_watchdog_rst_stagger.sv
// Registered per-channel reset vector: channel i leaves reset once the sequence count reaches
// HOLD_CYCLES + i*STAGGER, and every channel re-enters reset on HOLD or TIMEOUT.
module run_ctrl_watchdog_rst_stagger
  import run_ctrl_watchdog_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGGER     = 2,
  parameter int SEQ_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  state_e            nxt_state,
  input  logic [SEQ_W-1:0]  nxt_seq_cnt,
  output logic [NUM_CH-1:0] sys_rst_out
);

  logic [NUM_CH-1:0] rst_out_d, rst_out_q;
  logic              released;
  logic [31:0]       seq_ext;

  // Decoding from the next state/count keeps the outputs aligned with the FSM edge.
  always_comb begin
    released  = (nxt_state == ST_RELEASE) || (nxt_state == ST_RUN) || (nxt_state == ST_DONE);
    seq_ext   = 32'(nxt_seq_cnt);
    rst_out_d = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (released && (seq_ext >= 32'(HOLD_CYCLES + i * STAGGER))) begin
        rst_out_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_out_q <= '1;
    else        rst_out_q <= rst_out_d;
  end

  assign sys_rst_out = rst_out_q;

endmodule

// File: rtl/run_ctrl_watchdog.sv
// Run controller: staggered reset release, saturating run-cycle counter and kickable watchdog,
// with the end of a run latched as done (halt request) or timeout (watchdog expiry).
module run_ctrl_watchdog
  import run_ctrl_watchdog_pkg::*;
#(
  parameter int NUM_CH         = 3,
  parameter int HOLD_CYCLES    = 4,
  parameter int STAGGER        = 2,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              halt_req,
  input  logic              kick,
  output logic [NUM_CH-1:0] sys_rst_out,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int SEQ_LAST = HOLD_CYCLES + (NUM_CH - 1) * STAGGER;
  localparam int SEQ_W    = cnt_width(SEQ_LAST);
  localparam int WD_W     = cnt_width(TIMEOUT_CYCLES);
  localparam bit WD_ON    = (TIMEOUT_CYCLES > 0);

  localparam logic [SEQ_W-1:0] SEQ_LAST_V  = SEQ_W'(SEQ_LAST);
  localparam logic [SEQ_W-1:0] HOLD_LAST_V = SEQ_W'(HOLD_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST_V   = WD_W'(WD_ON ? TIMEOUT_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [SEQ_W-1:0]  seq_cnt_q, seq_cnt_d, seq_inc;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;

  always_comb begin
    seq_inc     = (seq_cnt_q < SEQ_LAST_V) ? seq_cnt_q + 1'b1 : seq_cnt_q;
    state_d     = state_q;
    seq_cnt_d   = seq_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    done_d      = done_q;
    timeout_d   = timeout_q;

    if (running_q && (cycle_cnt_q != {CNT_W{1'b1}})) begin
      cycle_cnt_d = cycle_cnt_q + 1'b1;
    end

    if (restart) begin
      state_d     = ST_HOLD;
      seq_cnt_d   = '0;
      wd_cnt_d    = '0;
      cycle_cnt_d = '0;
      done_d      = 1'b0;
      timeout_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          seq_cnt_d = seq_inc;
          if (seq_inc >= HOLD_LAST_V) state_d = ST_RELEASE;
        end
        ST_RELEASE: begin
          seq_cnt_d = seq_inc;
          if (seq_cnt_q == SEQ_LAST_V) begin
            state_d  = ST_RUN;
            wd_cnt_d = '0;
          end
        end
        // Halt outranks both a kick and a same-edge expiry.
        ST_RUN: begin
          if (halt_req) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (kick) begin
            wd_cnt_d = '0;
          end else if (WD_ON && (wd_cnt_q == WD_LAST_V)) begin
            state_d   = ST_TIMEOUT;
            timeout_d = 1'b1;
          end else if (WD_ON) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HOLD;
      seq_cnt_q   <= '0;
      wd_cnt_q    <= '0;
      cycle_cnt_q <= '0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_cnt_q   <= seq_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      running_q   <= running_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  run_ctrl_watchdog_rst_stagger #(
    .NUM_CH      (NUM_CH),
    .HOLD_CYCLES (HOLD_CYCLES),
    .STAGGER     (STAGGER),
    .SEQ_W       (SEQ_W)
  ) u_stagger (
    .clk         (clk),
    .rst_n       (rst_n),
    .nxt_state   (state_d),
    .nxt_seq_cnt (seq_cnt_d),
    .sys_rst_out (sys_rst_out)
  );

  assign running   = running_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_run_ctrl_watchdog.sv
// Directed plus randomized bench for run_ctrl_watchdog with an edge-level behavioural model.
module tb_run_ctrl_watchdog;

  localparam int NUM_CH = 3;
  localparam int HOLD   = 4;
  localparam int STAG   = 2;
  localparam int TO     = 16;
  localparam int CW     = 32;
  localparam int LAST   = HOLD + (NUM_CH - 1) * STAG;

  localparam int P_SEQ  = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;
  localparam int P_TO   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, restart, halt_req, kick;
  logic [NUM_CH-1:0] sys_rst_out;
  logic              running, done, timeout;
  logic [CW-1:0]     cycle_cnt;

  logic              rst_n2, restart2, halt2, kick2;
  logic [NUM_CH-1:0] sys_rst_out2;
  logic              running2, done2, timeout2;
  logic [3:0]        cycle_cnt2;

  run_ctrl_watchdog #(
    .NUM_CH(NUM_CH), .HOLD_CYCLES(HOLD), .STAGGER(STAG), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .halt_req(halt_req), .kick(kick),
    .sys_rst_out(sys_rst_out), .running(running), .done(done), .timeout(timeout),
    .cycle_cnt(cycle_cnt)
  );

  run_ctrl_watchdog #(
    .NUM_CH(NUM_CH), .HOLD_CYCLES(HOLD), .STAGGER(STAG), .TIMEOUT_CYCLES(0), .CNT_W(4)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n2), .restart(restart2), .halt_req(halt2), .kick(kick2),
    .sys_rst_out(sys_rst_out2), .running(running2), .done(done2), .timeout(timeout2),
    .cycle_cnt(cycle_cnt2)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase, edges since sequence start, edges since RUN entry / last kick.
  int     m_phase;
  int     m_k;
  int     m_since;
  longint m_cnt;
  bit     m_done, m_to;

  task automatic model_reset();
    m_phase = P_SEQ; m_k = 0; m_since = 0; m_cnt = 0; m_done = 0; m_to = 0;
  endtask

  task automatic model_edge(input logic r, input logic h, input logic k);
    if (!rst_n || r) begin
      model_reset();
    end else begin
      case (m_phase)
        P_SEQ: begin
          m_k++;
          if (m_k == LAST + 1) begin
            m_phase = P_RUN;
            m_since = 0;
          end
        end
        P_RUN: begin
          m_cnt++;
          if (h) begin
            m_phase = P_DONE; m_done = 1;
          end else if (k) begin
            m_since = 0;
          end else begin
            m_since++;
            if (m_since == TO) begin
              m_phase = P_TO; m_to = 1;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [NUM_CH-1:0] exp_rst();
    logic [NUM_CH-1:0] v;
    v = '1;
    if (m_phase == P_SEQ) begin
      for (int i = 0; i < NUM_CH; i++) v[i] = (m_k < HOLD + i * STAG);
    end else if (m_phase != P_TO) begin
      v = '0;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rst"},     32'(sys_rst_out), 32'(exp_rst()));
    chk({tag, ".running"}, 32'(running),     32'(m_phase == P_RUN));
    chk({tag, ".done"},    32'(done),        32'(m_done));
    chk({tag, ".timeout"}, 32'(timeout),     32'(m_to));
    chk({tag, ".cnt"},     cycle_cnt,        m_cnt[31:0]);
  endtask

  task automatic step(input string tag, input logic r, input logic h, input logic k);
    restart = r; halt_req = h; kick = k;
    @(posedge clk);
    model_edge(r, h, k);
    #1;
    check_all(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; restart = 1'b0; halt_req = 1'b0; kick = 1'b0;
    rst_n2 = 1'b0; restart2 = 1'b0; halt2 = 1'b0; kick2 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.rst_const", 32'(sys_rst_out), 32'h7);

    // Release sequence
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) step("t1", 1'b0, 1'b0, 1'b0);
    chk("t1.cnt_edge10", cycle_cnt, 32'd1);

    // Watchdog kept alive, then left to expire
    for (int i = 0; i < 100; i++) step("t2kick", 1'b0, 1'b0, (i % 10) == 9);
    chk("t2.alive", 32'(timeout), 32'd0);
    for (int i = 1; i <= 15; i++) step("t2wait", 1'b0, 1'b0, 1'b0);
    chk("t2.not_yet", 32'(timeout), 32'd0);
    step("t2exp", 1'b0, 1'b0, 1'b0);
    chk("t2.timeout", 32'(timeout), 32'd1);
    chk("t2.rst_all", 32'(sys_rst_out), 32'h7);
    for (int i = 0; i < 3; i++) step("t2frozen", 1'b0, 1'b1, 1'b1);

    // Halt and expiry on the same edge
    step("t3rst", 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) step("t3seq", 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) step("t3run", 1'b0, 1'b0, 1'b0);
    step("t3col", 1'b0, 1'b1, 1'b0);
    chk("t3.done", 32'(done), 32'd1);
    chk("t3.timeout", 32'(timeout), 32'd0);
    chk("t3.rst", 32'(sys_rst_out), 32'h0);

    // Restart from DONE
    step("t4rst", 1'b1, 1'b0, 1'b0);
    chk("t4.cnt0", cycle_cnt, 32'd0);
    chk("t4.rst_all", 32'(sys_rst_out), 32'h7);
    for (int i = 1; i <= 12; i++) step("t4seq", 1'b0, 1'b0, 1'b0);
    step("t4kickhalt", 1'b0, 1'b1, 1'b1);
    chk("t4.halt_wins", 32'(done), 32'd1);
    step("t4rst_mid", 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) step("t4seq2", 1'b0, 1'b0, 1'b0);
    step("t4rst_rel", 1'b1, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 13) == 0));
    end

    // Halt held during HOLD/RELEASE, then async reset mid-run
    step("t5rst", 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) step("t5seq_halt", 1'b0, 1'b1, 1'b0);
    chk("t5.running", 32'(running), 32'd1);
    for (int i = 1; i <= 5; i++) step("t5run", 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5.async_rst", 32'(sys_rst_out), 32'h7);
    chk("t5.async_running", 32'(running), 32'd0);
    chk("t5.async_done", 32'(done), 32'd0);
    chk("t5.async_timeout", 32'(timeout), 32'd0);
    chk("t5.async_cnt", cycle_cnt, 32'd0);
    @(posedge clk);
    #1;
    model_reset();
    check_all("t5hold");
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) step("t5rel", 1'b0, 1'b0, 1'b0);

    // Saturating counter with watchdog disabled
    rst_n2 = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      @(posedge clk);
      #1;
      chk("t6.cnt", 32'(cycle_cnt2), (j <= 9) ? 32'd0 : ((j - 9 > 15) ? 32'd15 : 32'(j - 9)));
      chk("t6.timeout", 32'(timeout2), 32'd0);
    end
    chk("t6.running", 32'(running2), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
